uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Buffered 8N1 UART transmitter; return path for the serial link whose receive side is driven by the RX pin.
- Core logic pushes bytes into an internal FIFO; block serialises them LSB-first onto TX at 115200 baud from the 25 MHz board clock.
- Instanced in top; drives the board TX pin.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per serial bit (25 MHz / 115200 = 217).
- FIFO_DEPTH, 16, byte entries in the transmit FIFO; power of two, >= 2.

Ports:
- CLK  input  1  system clock, 25 MHz.
- SW1  input  1  reset; synchronous, active-high.
- DATA_IN  input  8  byte to transmit.
- DATA_VALID  input  1  DATA_IN valid this cycle.
- READY  output  1  FIFO can accept a byte.
- TX  output  1  serial line out; idles high.
- BUSY  output  1  frame in progress or FIFO non-empty.

Behaviour:
- Reset (SW1=1 at a rising edge): state IDLE, FIFO flushed, baud and bit counters cleared, TX=1, BUSY=0. READY=0 while SW1=1.
- READY = (count != FIFO_DEPTH) && !SW1. This is combinational from registered count.
- Accept: a byte is accepted on a rising edge with DATA_VALID && READY. DATA_VALID with READY=0 is ignored: the byte is dropped with no error flag.
- FIFO: circular buffer with read/write pointers and a count of width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH. A push and a pop on the same edge leave count unchanged.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
  - IDLE: TX=1. If count != 0, pop the head byte into a shift register, go to START and register TX=0.
  - START: TX=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TX = shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit index. After 8 bits, go to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles. At the end, if count != 0, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1 and resets on every state or bit change. Every bit is held exactly CLKS_PER_BIT cycles.
- Frame length: 10*CLKS_PER_BIT = 2170 cycles.
- Latency: TX falls at the first rising edge after the accept edge when the block is IDLE with an empty FIFO.
- TX is driven from a flop (glitch-free).
- BUSY = (state != IDLE) || (count != 0), registered-equivalent; BUSY=0 only when the line is idle and nothing is queued.
- Push on the same edge as a pop while full is impossible, because READY=0 when full.
- SW1 asserted mid-frame: the frame is abandoned, TX=1 at that edge, FIFO is emptied and queued bytes are lost.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state between DATA and STOP transmits the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame becomes 11 bits = 2387 cycles.
- Undefined: no PARITY state and no parity logic; plain 8N1.

Test Plan:
- After reset, push 0x28 once. Expect:
  - TX low one edge after accept.
  - Mid-bit samples (every 217 cycles, offset 108): 0, 0,0,0,1,0,1,0,0, 1.
  - BUSY falls 2170 cycles after TX fell.
- Push 0x28, 0x28, 0x29 on consecutive cycles. Expect:
  - 30 contiguous bit periods (6510 cycles) with no idle gap.
  - Third frame data bits are 1,0,0,1,0,1,0,0.
  - BUSY deasserts afterward.
- Push 18 bytes on consecutive cycles (0x00..0x11). Expect:
  - READY low after the 17th accept (count=16, one byte already popped).
  - 0x11 is dropped.
  - Line carries 0x00..0x10 in order.
- Assert SW1 for one cycle during bit 3 of a 0xFF frame with 2 bytes queued. Expect:
  - TX=1 and BUSY=0 after that edge; READY=0 during the reset cycle.
  - Then push 0x55 and expect a clean 0x55 frame.
- DATA_VALID held high with READY=0 (full FIFO). Expect no count change and no corruption of queued data.
- With UART_TX_PARITY_EN defined, send 0x28 then 0x29. Expect parity bits 0 and 1 respectively, with 11-bit frames of 2387 cycles each.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 217,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic       CLK,
   input  logic       SW1,
   input  logic [7:0] DATA_IN,
   input  logic       DATA_VALID,
   output logic       READY,
   output logic       TX,
   output logic       BUSY
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t        state, state_n;
   logic [BW-1:0] baud, baud_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shift, shift_n;
   logic          tx_n;
   logic          baud_last;
   logic          push, pop;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic [7:0]    head;
`ifdef UART_TX_PARITY_EN
   logic          par, par_n;
`endif

   assign READY = (count != FULL) && !SW1;
   assign push  = DATA_VALID && READY;
   assign head  = mem[rd_ptr];
   assign BUSY  = (state != IDLE) || (count != '0);

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= DATA_IN;
   end

   always_ff @(posedge CLK) begin
      if (SW1) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (SW1) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         TX      <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         baud    <= baud_n;
         bit_idx <= bit_idx_n;
         shift   <= shift_n;
         TX      <= tx_n;
`ifdef UART_TX_PARITY_EN
         par     <= par_n;
`endif
      end
   end

   // tx_n is the value TX takes at the next edge, so it always looks one bit ahead.
   always_comb begin
      state_n   = state;
      baud_n    = baud + 1'b1;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      tx_n      = TX;
      pop       = 1'b0;
      baud_last = (baud == BAUD_LAST);
`ifdef UART_TX_PARITY_EN
      par_n     = par;
`endif
      case (state)
         IDLE: begin
            baud_n = '0;
            tx_n   = 1'b1;
            if (count != '0) begin
               pop     = 1'b1;
               shift_n = head;
`ifdef UART_TX_PARITY_EN
               par_n   = ^head;
`endif
               state_n = START;
               tx_n    = 1'b0;
            end
         end
         START: begin
            if (baud_last) begin
               state_n   = DATA;
               baud_n    = '0;
               bit_idx_n = '0;
               tx_n      = shift[0];
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_n = '0;
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_n = PARITY;
                  tx_n    = par;
`else
                  state_n = STOP;
                  tx_n    = 1'b1;
`endif
               end else begin
                  shift_n   = shift >> 1;
                  bit_idx_n = bit_idx + 1'b1;
                  tx_n      = shift[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_last) begin
               state_n = STOP;
               baud_n  = '0;
               tx_n    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (baud_last) begin
               baud_n = '0;
               if (count != '0) begin
                  pop     = 1'b1;
                  shift_n = head;
`ifdef UART_TX_PARITY_EN
                  par_n   = ^head;
`endif
                  state_n = START;
                  tx_n    = 1'b0;
               end else begin
                  state_n = IDLE;
                  tx_n    = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
         end
      endcase
   end

endmodule
